// File: rtl/axi4_wr_arbiter.sv
// Round-robin AXI4 write arbiter: NUM_M masters share one slave port, one AW->W->B transaction at a time.
// Latency: one registered arbitration cycle before AW; AW, W and B then pass through combinationally.
// Backpressure: ready/valid reach only the owning master; every other master sees ready=0 and stalls.
module axi4_wr_arbiter #(
    parameter int NUM_M  = 2,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64,
    parameter int ID_W   = 4,
    localparam int GW     = (NUM_M > 1) ? $clog2(NUM_M) : 1,
    localparam int STRB_W = DATA_W / 8
) (
    input  logic                    aclk,
    input  logic                    areset,
    input  logic [NUM_M-1:0]        s_awvalid,
    output logic [NUM_M-1:0]        s_awready,
    input  logic [NUM_M*ADDR_W-1:0] s_awaddr,
    input  logic [NUM_M*8-1:0]      s_awlen,
    input  logic [NUM_M*ID_W-1:0]   s_awid,
    input  logic [NUM_M-1:0]        s_wvalid,
    output logic [NUM_M-1:0]        s_wready,
    input  logic [NUM_M*DATA_W-1:0] s_wdata,
    input  logic [NUM_M*STRB_W-1:0] s_wstrb,
    input  logic [NUM_M-1:0]        s_wlast,
    output logic [NUM_M-1:0]        s_bvalid,
    input  logic [NUM_M-1:0]        s_bready,
    output logic [1:0]              s_bresp,
    output logic [ID_W-1:0]         s_bid,
    output logic                    m_awvalid,
    input  logic                    m_awready,
    output logic [ADDR_W-1:0]       m_awaddr,
    output logic [7:0]              m_awlen,
    output logic [ID_W-1:0]         m_awid,
    output logic                    m_wvalid,
    input  logic                    m_wready,
    output logic [DATA_W-1:0]       m_wdata,
    output logic [STRB_W-1:0]       m_wstrb,
    output logic                    m_wlast,
    input  logic                    m_bvalid,
    output logic                    m_bready,
    input  logic [1:0]              m_bresp,
    input  logic [ID_W-1:0]         m_bid,
    output logic [GW-1:0]           grant,
    output logic                    busy,
    output logic                    len_err
);

    typedef enum logic [1:0] {ST_IDLE, ST_AW, ST_W, ST_B} state_t;

    state_t        state;
    logic [GW-1:0] rr_ptr;
    logic [GW-1:0] pick;
    logic [GW:0]   rr_idx;
    logic [7:0]    len_q;
    logic [8:0]    beat;
    logic [8:0]    beat_nxt;
    logic          w_at_len;
    logic          aw_hs;
    logic          w_hs;
    logic          b_hs;

    // Search downward so the requester closest to rr_ptr is the last to overwrite pick.
    always_comb begin
        pick   = rr_ptr;
        rr_idx = '0;
        for (int i = NUM_M - 1; i >= 0; i--) begin
            rr_idx = {1'b0, rr_ptr} + (GW+1)'(i);
            if (rr_idx >= (GW+1)'(NUM_M))
                rr_idx = rr_idx - (GW+1)'(NUM_M);
            if (s_awvalid[rr_idx[GW-1:0]])
                pick = rr_idx[GW-1:0];
        end
    end

    assign m_awvalid = (state == ST_AW) && s_awvalid[grant];
    assign m_awaddr  = s_awaddr[int'(grant)*ADDR_W +: ADDR_W];
    assign m_awlen   = s_awlen[int'(grant)*8 +: 8];
    assign m_awid    = s_awid[int'(grant)*ID_W +: ID_W];

    assign m_wvalid  = (state == ST_W) && s_wvalid[grant];
    assign m_wdata   = s_wdata[int'(grant)*DATA_W +: DATA_W];
    assign m_wstrb   = s_wstrb[int'(grant)*STRB_W +: STRB_W];
    assign m_wlast   = s_wlast[grant];

    assign m_bready  = (state == ST_B) && s_bready[grant];
    assign s_bresp   = m_bresp;
    assign s_bid     = m_bid;

    always_comb begin
        s_awready        = '0;
        s_wready         = '0;
        s_bvalid         = '0;
        s_awready[grant] = (state == ST_AW) && m_awready;
        s_wready[grant]  = (state == ST_W) && m_wready;
        s_bvalid[grant]  = (state == ST_B) && m_bvalid;
    end

    assign aw_hs    = m_awvalid && m_awready;
    assign w_hs     = m_wvalid && m_wready;
    assign b_hs     = (state == ST_B) && m_bvalid && s_bready[grant];
    assign beat_nxt = (beat == 9'd256) ? beat : beat + 9'd1;
    assign w_at_len = (beat_nxt == ({1'b0, len_q} + 9'd1));

    always_ff @(posedge aclk) begin
        if (areset) begin
            state   <= ST_IDLE;
            rr_ptr  <= '0;
            grant   <= '0;
            busy    <= 1'b0;
            len_err <= 1'b0;
            len_q   <= '0;
            beat    <= '0;
        end else begin
            len_err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (|s_awvalid) begin
                        state <= ST_AW;
                        busy  <= 1'b1;
                        grant <= pick;
                        len_q <= s_awlen[int'(pick)*8 +: 8];
                        beat  <= '0;
                    end
                end
                ST_AW: begin
                    if (aw_hs)
                        state <= ST_W;
                end
                ST_W: begin
                    if (w_hs) begin
                        beat <= beat_nxt;
                        // A missing WLAST is flagged once, on the beat that should have carried it.
                        if (m_wlast) begin
                            len_err <= !w_at_len;
                            state   <= ST_B;
                        end else begin
                            len_err <= w_at_len && (beat_nxt != beat);
                        end
                    end
                end
                ST_B: begin
                    if (b_hs) begin
                        state  <= ST_IDLE;
                        busy   <= 1'b0;
                        rr_ptr <= (grant == GW'(NUM_M - 1)) ? '0 : grant + GW'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi4_wr_arbiter.sv
// Self-checking bench for axi4_wr_arbiter (NUM_M=4): directed bursts, length errors, reset, and a
// randomized multi-master run scored against a transaction-level round-robin model.
module tb_axi4_wr_arbiter;

    localparam int NM = 4;

    logic          aclk;
    logic          areset;
    logic [3:0]    s_awvalid, s_awready;
    logic [127:0]  s_awaddr;
    logic [31:0]   s_awlen;
    logic [15:0]   s_awid;
    logic [3:0]    s_wvalid, s_wready;
    logic [255:0]  s_wdata;
    logic [31:0]   s_wstrb;
    logic [3:0]    s_wlast;
    logic [3:0]    s_bvalid, s_bready;
    logic [1:0]    s_bresp;
    logic [3:0]    s_bid;
    logic          m_awvalid, m_awready;
    logic [31:0]   m_awaddr;
    logic [7:0]    m_awlen;
    logic [3:0]    m_awid;
    logic          m_wvalid, m_wready;
    logic [63:0]   m_wdata;
    logic [7:0]    m_wstrb;
    logic          m_wlast;
    logic          m_bvalid, m_bready;
    logic [1:0]    m_bresp;
    logic [3:0]    m_bid;
    logic [1:0]    grant;
    logic          busy;
    logic          len_err;

    int n_chk = 0;
    int n_err = 0;
    int glist[$];
    int busy_low;

    axi4_wr_arbiter #(.NUM_M(NM), .ADDR_W(32), .DATA_W(64), .ID_W(4)) dut (
        .aclk(aclk), .areset(areset),
        .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr), .s_awlen(s_awlen),
        .s_awid(s_awid), .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata),
        .s_wstrb(s_wstrb), .s_wlast(s_wlast), .s_bvalid(s_bvalid), .s_bready(s_bready),
        .s_bresp(s_bresp), .s_bid(s_bid),
        .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr), .m_awlen(m_awlen),
        .m_awid(m_awid), .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata),
        .m_wstrb(m_wstrb), .m_wlast(m_wlast), .m_bvalid(m_bvalid), .m_bready(m_bready),
        .m_bresp(m_bresp), .m_bid(m_bid),
        .grant(grant), .busy(busy), .len_err(len_err)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [63:0] bdat(input int m, input int s, input int b);
        return {8'(m), 8'(s), 8'(b), 8'hC3, 32'(s * 977 + b * 31 + m * 7)};
    endfunction

    function automatic logic [31:0] addr_of(input int m, input int s);
        return 32'((m << 24) | (s << 8));
    endfunction

    task automatic clear_inputs();
        s_awvalid = '0; s_awaddr = '0; s_awlen = '0; s_awid = '0;
        s_wvalid = '0; s_wdata = '0; s_wstrb = '0; s_wlast = '0; s_bready = '0;
        m_awready = 0; m_wready = 0; m_bvalid = 0; m_bresp = '0; m_bid = '0;
    endtask

    task automatic set_aw(input int m, input bit v, input logic [31:0] a, input logic [7:0] l,
                          input logic [3:0] id);
        s_awvalid[m] = v;
        s_awaddr[m*32 +: 32] = a;
        s_awlen[m*8 +: 8] = l;
        s_awid[m*4 +: 4] = id;
    endtask

    task automatic set_w(input int m, input bit v, input logic [63:0] d, input bit last);
        s_wvalid[m] = v;
        s_wdata[m*64 +: 64] = d;
        s_wstrb[m*8 +: 8] = 8'hFF;
        s_wlast[m] = last;
    endtask

    task automatic do_reset();
        @(posedge aclk); #1;
        areset = 1;
        clear_inputs();
        repeat (2) @(posedge aclk);
        #1 areset = 0;
        @(negedge aclk);
        chk("rst_busy", busy, 0);
        chk("rst_grant", grant, 0);
        chk("rst_len_err", len_err, 0);
        chk("rst_vr", {m_awvalid, m_wvalid, m_bready, s_awready, s_wready, s_bvalid}, 0);
    endtask

    // One master, all slave-side readies high; WLAST placed on beat last_beat (1-based).
    task automatic run_tx(input int m, input int len, input int last_beat, input int rst_beat,
                          output int b_cyc, output int nbeats, output int nerr, output int err_cyc);
        int beats;
        bit aw_done, done;
        logic [3:0] id;
        id = 4'(m + len + 5);
        beats = 0; aw_done = 0; done = 0;
        b_cyc = -1; nbeats = 0; nerr = 0; err_cyc = -1;
        for (int cyc = 0; cyc < 40 && !done; cyc++) begin
            @(posedge aclk); #1;
            m_awready = 1; m_wready = 1; m_bvalid = 1; m_bresp = 2'd0; m_bid = id; s_bready = '1;
            set_aw(m, !aw_done, addr_of(m, 0), 8'(len), id);
            set_w(m, beats < last_beat, bdat(m, 0, beats), beats + 1 == last_beat);
            if (rst_beat != 0 && aw_done && beats == rst_beat - 1) areset = 1;
            @(negedge aclk);
            if (len_err) begin
                nerr++;
                if (err_cyc < 0) err_cyc = cyc;
            end
            if (m_awvalid && m_awready) begin
                chk("aw_grant", grant, m);
                chk("aw_len", m_awlen, len);
                chk("aw_addr", m_awaddr, addr_of(m, 0));
            end
            if (m_wvalid && m_wready) begin
                chk("w_data", m_wdata, bdat(m, 0, nbeats));
                chk("w_last", m_wlast, nbeats + 1 == last_beat);
                nbeats++;
            end
            if (s_bvalid[m] && s_bready[m]) begin
                b_cyc = cyc;
                chk("b_id", s_bid, id);
                chk("b_resp", s_bresp, 0);
                done = 1;
            end
            if (s_awvalid[m] && s_awready[m]) aw_done = 1;
            if (s_wvalid[m] && s_wready[m]) beats++;
            if (areset) begin
                @(posedge aclk); #1;
                areset = 0;
                clear_inputs();
                @(negedge aclk);
                chk("mid_rst_busy", busy, 0);
                chk("mid_rst_grant", grant, 0);
                chk("mid_rst_vr", {m_awvalid, m_wvalid, m_bready, s_awready, s_wready, s_bvalid}, 0);
                done = 1;
            end
        end
        clear_inputs();
    endtask

    // Multi-master run against a transaction-level model: round-robin winner from the request
    // snapshot of each idle cycle, one burst at a time, B returned with the burst's own ID.
    task automatic run_engine(input logic [3:0] mask, input int quota, input bit rnd_bp,
                              input bit rnd_len, input bit early_w, input bit rnd_gap);
        int seq[NM], beat[NM], gap[NM], waitc[NM], clen[NM];
        logic [3:0] cid[NM];
        bit awdone[NM];
        int ph, own, rr, done_cnt, total, win, idx, cyc;
        bit found, hs_aw, hs_w, hs_b, lastw, slv_b, req, wv, act;
        logic [3:0] prev_req, slv_id;
        logic [1:0] slv_resp;
        glist.delete();
        busy_low = 0;
        total = 0;
        for (int m = 0; m < NM; m++) begin
            seq[m] = 0; beat[m] = 0; waitc[m] = 0; awdone[m] = 0;
            gap[m] = rnd_gap ? $urandom_range(0, 3) : 0;
            clen[m] = rnd_len ? $urandom_range(0, 7) : 0;
            cid[m] = 4'($urandom);
            if (mask[m]) total += quota;
        end
        ph = 0; own = 0; rr = 0; done_cnt = 0; slv_b = 0; slv_id = '0; slv_resp = '0;
        hs_aw = 0; hs_w = 0; hs_b = 0; lastw = 0; prev_req = '0;
        for (cyc = 0; cyc < 20000; cyc++) begin
            @(posedge aclk); #1;
            if (ph == 0) begin
                if (prev_req != 0) begin
                    found = 0; win = 0;
                    for (int k = 0; k < NM; k++) begin
                        idx = (rr + k) % NM;
                        if (!found && prev_req[idx]) begin found = 1; win = idx; end
                    end
                    for (int m = 0; m < NM; m++)
                        if (prev_req[m] && m != win) waitc[m]++;
                    chk("fairness", waitc[win] <= 3, 1);
                    waitc[win] = 0;
                    own = win; ph = 1;
                    glist.push_back(win);
                end
            end else if (hs_aw) begin
                ph = 2; awdone[own] = 1;
            end else if (hs_w) begin
                beat[own]++;
                if (lastw) begin
                    ph = 3; slv_b = 1; slv_id = cid[own]; slv_resp = 2'($urandom);
                end
            end else if (hs_b) begin
                slv_b = 0; ph = 0; rr = (own + 1) % NM; done_cnt++;
                seq[own]++; awdone[own] = 0; beat[own] = 0;
                gap[own] = rnd_gap ? $urandom_range(0, 3) : 0;
                clen[own] = rnd_len ? $urandom_range(0, 7) : 0;
                cid[own] = 4'($urandom);
            end
            if (done_cnt == total) break;
            for (int m = 0; m < NM; m++) begin
                act = mask[m] && seq[m] < quota;
                req = act && !awdone[m] && gap[m] == 0;
                if (act && !awdone[m] && gap[m] > 0) gap[m]--;
                if (awdone[m] && beat[m] <= clen[m]) wv = rnd_bp ? ($urandom_range(0, 3) != 0) : 1'b1;
                else wv = req && early_w;
                set_aw(m, req, addr_of(m, seq[m]), 8'(clen[m]), cid[m]);
                set_w(m, wv, bdat(m, seq[m], beat[m]), beat[m] == clen[m]);
                s_bready[m] = rnd_bp ? ($urandom_range(0, 9) < 7) : 1'b1;
            end
            m_awready = rnd_bp ? ($urandom_range(0, 9) < 6) : 1'b1;
            m_wready  = rnd_bp ? ($urandom_range(0, 9) < 7) : 1'b1;
            m_bvalid = slv_b; m_bid = slv_id; m_bresp = slv_resp;
            @(negedge aclk);
            chk("len_err", len_err, 0);
            chk("busy", busy, ph != 0);
            if (!busy) busy_low++;
            case (ph)
                0: chk("idle_vr", {m_awvalid, m_wvalid, m_bready, s_awready, s_wready, s_bvalid}, 0);
                1: begin
                    chk("aw_grant", grant, own);
                    chk("aw_valid", m_awvalid, 1);
                    chk("aw_addr", m_awaddr, addr_of(own, seq[own]));
                    chk("aw_len", m_awlen, clen[own]);
                    chk("aw_id", m_awid, cid[own]);
                    chk("aw_rdy", s_awready, m_awready ? (4'b1 << own) : 4'b0);
                    chk("aw_other", {m_wvalid, m_bready, s_wready, s_bvalid}, 0);
                end
                2: begin
                    chk("w_grant", grant, own);
                    chk("w_valid", m_wvalid, s_wvalid[own]);
                    if (s_wvalid[own]) begin
                        chk("w_data", m_wdata, bdat(own, seq[own], beat[own]));
                        chk("w_last", m_wlast, beat[own] == clen[own]);
                    end
                    chk("w_rdy", s_wready, m_wready ? (4'b1 << own) : 4'b0);
                    chk("w_other", {m_awvalid, m_bready, s_awready, s_bvalid}, 0);
                end
                default: begin
                    chk("b_grant", grant, own);
                    chk("b_valid", s_bvalid, slv_b ? (4'b1 << own) : 4'b0);
                    if (slv_b) begin
                        chk("b_id", s_bid, slv_id);
                        chk("b_resp", s_bresp, slv_resp);
                    end
                    chk("b_rdy", m_bready, s_bready[own]);
                    chk("b_other", {m_awvalid, m_wvalid, s_awready, s_wready}, 0);
                end
            endcase
            hs_aw = (ph == 1) && s_awvalid[own] && m_awready;
            hs_w  = (ph == 2) && s_wvalid[own] && m_wready;
            lastw = s_wlast[own];
            hs_b  = (ph == 3) && slv_b && s_bready[own];
            prev_req = s_awvalid;
        end
        chk("engine_done", done_cnt, total);
        clear_inputs();
    endtask

    initial begin
        int bc, nb, ne, ec;
        areset = 1;
        clear_inputs();

        // Single burst, AWLEN=3, everything ready.
        do_reset();
        run_tx(0, 3, 4, 0, bc, nb, ne, ec);
        chk("t1_b_cycle", bc, 6);
        chk("t1_beats", nb, 4);
        chk("t1_len_err", ne, 0);

        // Two masters requesting continuously, single-beat bursts.
        do_reset();
        run_engine(4'b0011, 2, 0, 0, 0, 0);
        chk("t2_ngrants", glist.size(), 4);
        for (int i = 0; i < glist.size(); i++) chk("t2_grant_order", glist[i], i % 2);
        chk("t2_idle_cycles", busy_low, 4);

        // Master 1 offers W data early while master 0 owns the bus.
        do_reset();
        run_engine(4'b0011, 1, 0, 1, 1, 0);
        chk("t3_ngrants", glist.size(), 2);
        if (glist.size() == 2) begin
            chk("t3_first", glist[0], 0);
            chk("t3_second", glist[1], 1);
        end

        // WLAST early on beat 2 of a 4-beat burst.
        do_reset();
        run_tx(0, 3, 2, 0, bc, nb, ne, ec);
        chk("t4a_beats", nb, 2);
        chk("t4a_nerr", ne, 1);
        chk("t4a_err_cycle", ec, 4);
        chk("t4a_b_cycle", bc, 4);

        // No WLAST on beat 4; WLAST finally on beat 5 is also a mismatch.
        do_reset();
        run_tx(0, 3, 5, 0, bc, nb, ne, ec);
        chk("t4b_beats", nb, 5);
        chk("t4b_nerr", ne, 2);
        chk("t4b_err_cycle", ec, 6);
        chk("t4b_b_cycle", bc, 7);

        // Randomized backpressure, four masters, 200 bursts.
        do_reset();
        run_engine(4'b1111, 50, 1, 1, 1, 1);
        chk("t5_ngrants", glist.size(), 200);

        // Reset during beat 2, then master 2 alone.
        do_reset();
        run_tx(0, 3, 4, 2, bc, nb, ne, ec);
        run_tx(2, 0, 1, 0, bc, nb, ne, ec);
        chk("t6_b_cycle", bc, 3);
        chk("t6_beats", nb, 1);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
